// File: rtl/multicycle_ctrl.sv
// Main control FSM and ALU/immediate decoder for the multicycle core.
// Raw write requests go to cond_logic, which gates them with cond_ex.
module multicycle_ctrl #(
  parameter int ST_W  = 4,
  parameter int ALU_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic             mem_ready,
  output logic             pcs,
  output logic             reg_w,
  output logic             mem_w,
  output logic [1:0]       flag_w,
  output logic             no_write,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [1:0]       reg_src,
  output logic [ALU_W-1:0] alu_control,
  output logic [ST_W-1:0]  state
);

  typedef enum logic [ST_W-1:0] {
    FETCH   = ST_W'(0),
    DECODE  = ST_W'(1),
    MEMADR  = ST_W'(2),
    MEMRD   = ST_W'(3),
    MEMWB   = ST_W'(4),
    MEMWR   = ST_W'(5),
    EXECR   = ST_W'(6),
    EXECI   = ST_W'(7),
    ALUWB   = ST_W'(8),
    BRANCH  = ST_W'(9),
    ILLEGAL = ST_W'(15)
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       mem_w;
    logic       reg_w;
    logic       pcs_rd;
    logic       pcs_br;
  } ctl_t;

  state_t     st;
  state_t     nxt;
  ctl_t       ctl;
  logic [3:0] cmd;

  assign cmd = funct[4:1];

  // Moore control values, evaluated for the state being entered so they register with it.
  function automatic ctl_t ctl_for(state_t s, logic imm);
    ctl_t c;
    c = '0;
    case (s)
      FETCH, DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      MEMADR: c.alu_src_b = 2'b01;
      MEMRD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
        c.pcs_rd     = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECR:  c.alu_src_b = 2'b00;
      EXECI:  c.alu_src_b = 2'b01;
      ALUWB: begin
        c.alu_src_b = imm ? 2'b01 : 2'b00;
        c.reg_w     = 1'b1;
        c.pcs_rd    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pcs_br     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [ALU_W-1:0] alu_dec(logic [3:0] c);
    case (c)
      4'b0010, 4'b1010: return ALU_W'(1);
      4'b0000:          return ALU_W'(2);
      4'b1100:          return ALU_W'(3);
      default:          return ALU_W'(0);
    endcase
  endfunction

  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b00:   nxt = funct[5] ? EXECI : EXECR;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = ILLEGAL;
        endcase
      end
      MEMADR: nxt = funct[0] ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXECR, EXECI: nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st  <= FETCH;
      ctl <= ctl_for(FETCH, 1'b0);
    end else begin
      st  <= nxt;
      ctl <= ctl_for(nxt, funct[5]);
    end
  end

  // ALU decode is live through EXEC and ALUWB so alu_flag stays valid at writeback.
  assign alu_control = (st == EXECR || st == EXECI || st == ALUWB) ? alu_dec(cmd) : ALU_W'(0);
  assign flag_w      = (st == ALUWB && funct[0])
                     ? {1'b1, (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)} : 2'b00;
  assign no_write    = (st == ALUWB) && (cmd == 4'b1010);

  assign pc_write   = (st == FETCH) && mem_ready;
  assign ir_write   = (st == FETCH) && mem_ready;
  assign pcs        = ctl.pcs_br | (ctl.pcs_rd & (rd == 4'd15));
  assign reg_w      = ctl.reg_w;
  assign mem_w      = ctl.mem_w;
  assign adr_src    = ctl.adr_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign result_src = ctl.result_src;
  assign imm_src    = op;
  assign reg_src    = {op == 2'b01, op == 2'b10};
  assign state      = st;

endmodule
